// File: rtl/dp_exec_mem_slice_pkg.sv
// Shared widths and ALU opcodes for the execute/memory/write-back datapath slice.
package dp_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned RA_W     = 3;
  localparam int unsigned DMEM_AW  = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SH_W     = 4;
  localparam int unsigned REG_N    = 2 ** RA_W;
  localparam int unsigned MEM_N    = 2 ** DMEM_AW;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SHL = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SHR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/dp_exec_mem_slice_if.sv
// Decoded controls in, datapath observation values out.
interface dp_exec_mem_slice_if;
  import dp_pkg::*;

  logic [RA_W-1:0]     rs_addr;
  logic [RA_W-1:0]     rt_addr;
  logic [RA_W-1:0]     rd_addr;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_ctrl;
  logic                alu_src;
  logic [DW-1:0]       imm;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic [DW-1:0]       rs_data;
  logic [DW-1:0]       rt_data;
  logic [DW-1:0]       alu_result;
  logic                zero;
  logic [DW-1:0]       wb_data;

  modport master (
    output rs_addr, rt_addr, rd_addr, reg_write, alu_ctrl, alu_src, imm,
           mem_read, mem_write, mem_to_reg,
    input  rs_data, rt_data, alu_result, zero, wb_data
  );

  modport slave (
    input  rs_addr, rt_addr, rd_addr, reg_write, alu_ctrl, alu_src, imm,
           mem_read, mem_write, mem_to_reg,
    output rs_data, rt_data, alu_result, zero, wb_data
  );

endinterface

// File: rtl/dp_exec_mem_slice_alu.sv
// Combinational 16-bit ALU with zero flag.
module dp_alu16
  import dp_pkg::*;
(
  input  logic [DW-1:0]       a,
  input  logic [DW-1:0]       b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [DW-1:0]       result,
  output logic                zero
);

  // Operation select; shifts use only the low nibble of B
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_NOT: result = ~a;
      ALU_SHL: result = a << b[SH_W-1:0];
      ALU_SHR: result = a >> b[SH_W-1:0];
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = DW'(a < b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/dp_exec_mem_slice.sv
// Execute/memory/write-back slice: register file, ALU, data memory, write-back mux.
module dp_exec_mem_slice
  import dp_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  dp_exec_mem_slice_if.slave bus
);

  logic [DW-1:0]      regs [REG_N];
  logic [DW-1:0]      dmem [MEM_N];
  logic [DW-1:0]      rs_data;
  logic [DW-1:0]      rt_data;
  logic [DW-1:0]      opb;
  logic [DW-1:0]      alu_result;
  logic               zero;
  logic [DMEM_AW-1:0] mem_idx;
  logic [DW-1:0]      mem_rdata;
  logic [DW-1:0]      wb_data;

  assign rs_data = regs[bus.rs_addr];
  assign rt_data = regs[bus.rt_addr];
  assign opb     = bus.alu_src ? bus.imm : rt_data;

  dp_alu16 u_alu (
    .a      (rs_data),
    .b      (opb),
    .op     (bus.alu_ctrl),
    .result (alu_result),
    .zero   (zero)
  );

  // Memory index wraps: upper address bits are ignored
  assign mem_idx   = alu_result[DMEM_AW-1:0];
  assign mem_rdata = bus.mem_read ? dmem[mem_idx] : '0;
  assign wb_data   = bus.mem_to_reg ? mem_rdata : alu_result;

  assign bus.rs_data    = rs_data;
  assign bus.rt_data    = rt_data;
  assign bus.alu_result = alu_result;
  assign bus.zero       = zero;
  assign bus.wb_data    = wb_data;

  // Register file write-back, no bypass to same-cycle reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (bus.reg_write) begin
      regs[bus.rd_addr] <= wb_data;
    end
  end

  // Data memory store of rt_data at the ALU-computed index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_N; i++) dmem[i] <= '0;
    end else if (bus.mem_write) begin
      dmem[mem_idx] <= rt_data;
    end
  end

endmodule

// File: tb/tb_dp_exec_mem_slice.sv
// Directed self-checking bench for the datapath execute/memory/write-back slice.
module tb_dp_exec_mem_slice;
  import dp_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dp_exec_mem_slice_if bus ();

  dp_exec_mem_slice dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rs_addr    = '0;
    bus.rt_addr    = '0;
    bus.rd_addr    = '0;
    bus.reg_write  = 1'b0;
    bus.alu_ctrl   = ALU_ADD;
    bus.alu_src    = 1'b0;
    bus.imm        = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
  endtask

  // Load an immediate into a register through R0 + imm (R0 is never written here)
  task automatic write_reg(input logic [RA_W-1:0] rd, input logic [DW-1:0] val);
    @(negedge clk);
    idle();
    bus.alu_src   = 1'b1;
    bus.imm       = val;
    bus.rd_addr   = rd;
    bus.reg_write = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < REG_N; i++) begin
      bus.rs_addr = RA_W'(i);
      #1;
      n_checks++;
      if (bus.rs_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_rs_data[%0d] got %h expected 0000", i, bus.rs_data);
      end
    end
    bus.rs_addr    = '0;
    bus.alu_src    = 1'b1;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    for (int i = 0; i < MEM_N; i++) begin
      bus.imm = DW'(i);
      #1;
      n_checks++;
      if (bus.wb_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_load[%0d] got %h expected 0000", i, bus.wb_data);
      end
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reg_write();
    @(negedge clk);
    idle();
    bus.alu_src   = 1'b1;
    bus.imm       = 16'h0005;
    bus.rd_addr   = 3'd1;
    bus.reg_write = 1'b1;
    bus.rt_addr   = 3'd1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL regw_wb got %h expected 0005", bus.wb_data);
    end
    n_checks++;
    if (bus.rt_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL regw_same_cycle_old got %h expected 0000", bus.rt_data);
    end
    @(posedge clk);
    #1;
    idle();
    bus.rs_addr = 3'd1;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL regw_readback got %h expected 0005", bus.rs_data);
    end
  endtask

  task automatic test_alu_sweep();
    logic [ALU_OP_W-1:0] ops [9];
    logic [DW-1:0]       exp [9];
    logic [DW-1:0]       bv  [9];
    logic                src [9];
    ops = '{ALU_ADD, ALU_SUB, ALU_NOT, ALU_SHL, ALU_SHR, ALU_AND, ALU_OR, ALU_SHL, ALU_SHR};
    // B = 0x000F from R6, except the last two which shift by imm 4
    exp = '{16'h00FF, 16'h00E1, 16'hFF0F, 16'h0000, 16'h0000, 16'h0000, 16'h00FF,
            16'h0F00, 16'h000F};
    bv  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0004};
    src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    write_reg(3'd5, 16'h00F0);
    write_reg(3'd6, 16'h000F);
    write_reg(3'd7, 16'h0001);
    @(negedge clk);
    idle();
    bus.rs_addr = 3'd5;
    bus.rt_addr = 3'd6;
    for (int i = 0; i < 9; i++) begin
      bus.alu_ctrl = ops[i];
      bus.alu_src  = src[i];
      bus.imm      = bv[i];
      #1;
      n_checks++;
      if (bus.alu_result !== exp[i] || bus.zero !== (exp[i] == 16'h0000)) begin
        n_fail++;
        $display("FAIL alu_op[%0d] got %h/z%b expected %h/z%b", i, bus.alu_result,
                 bus.zero, exp[i], (exp[i] == 16'h0000));
      end
    end
    bus.alu_ctrl = ALU_SLT;
    bus.alu_src  = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL alu_slt_false got %h expected 0000", bus.alu_result);
    end
    bus.rs_addr = 3'd7;
    bus.alu_src = 1'b1;
    bus.imm     = 16'h0002;
    #1;
    n_checks++;
    if (bus.alu_result !== 16'h0001 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_slt_true got %h/z%b expected 0001/z0", bus.alu_result, bus.zero);
    end
  endtask

  task automatic test_store_load();
    write_reg(3'd2, 16'h1234);
    @(negedge clk);
    idle();
    bus.alu_src    = 1'b1;
    bus.imm        = 16'h0003;
    bus.rt_addr    = 3'd2;
    bus.mem_write  = 1'b1;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL store_same_cycle_old got %h expected 0000", bus.wb_data);
    end
    @(posedge clk);
    #1;
    idle();
    bus.alu_src    = 1'b1;
    bus.imm        = 16'h0003;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    bus.rd_addr    = 3'd4;
    bus.reg_write  = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_wb got %h expected 1234", bus.wb_data);
    end
    @(posedge clk);
    #1;
    idle();
    bus.rs_addr = 3'd4;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_r4 got %h expected 1234", bus.rs_data);
    end
    bus.rs_addr    = 3'd0;
    bus.alu_src    = 1'b1;
    bus.imm        = 16'h000B;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_alias_11 got %h expected 1234", bus.wb_data);
    end
    bus.mem_read = 1'b0;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL load_no_read got %h expected 0000", bus.wb_data);
    end
  endtask

  task automatic test_back_to_back();
    // Store R2 to word 5 and write R3 = 5 on the same edge
    @(negedge clk);
    idle();
    bus.alu_src   = 1'b1;
    bus.imm       = 16'h0005;
    bus.rt_addr   = 3'd2;
    bus.mem_write = 1'b1;
    bus.rd_addr   = 3'd3;
    bus.reg_write = 1'b1;
    @(posedge clk);
    #1;
    idle();
    bus.rs_addr = 3'd3;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL dual_write_reg got %h expected 0005", bus.rs_data);
    end
    bus.rs_addr    = 3'd0;
    bus.alu_src    = 1'b1;
    bus.imm        = 16'h0005;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL dual_write_mem got %h expected 1234", bus.wb_data);
    end
  endtask

  task automatic test_neg_imm();
    @(negedge clk);
    idle();
    bus.rs_addr = 3'd1;
    bus.alu_src = 1'b1;
    bus.imm     = 16'hFFFE;
    #1;
    n_checks++;
    if (bus.alu_result !== 16'h0003 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_imm_add got %h/z%b expected 0003/z0", bus.alu_result, bus.zero);
    end
    bus.alu_src  = 1'b0;
    bus.rt_addr  = 3'd1;
    bus.alu_ctrl = ALU_SUB;
    #1;
    n_checks++;
    if (bus.alu_result !== 16'h0000 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_self_zero got %h/z%b expected 0000/z1", bus.alu_result, bus.zero);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    bus.rs_addr = 3'd4;
    bus.rt_addr = 3'd2;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL pre_reset_r4 got %h expected 1234", bus.rs_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h0000 || bus.rt_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_regs got %h/%h expected 0000/0000", bus.rs_data, bus.rt_data);
    end
    bus.rs_addr    = 3'd0;
    bus.alu_src    = 1'b1;
    bus.imm        = 16'h0003;
    bus.mem_read   = 1'b1;
    bus.mem_to_reg = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_mem got %h expected 0000", bus.wb_data);
    end
    // Writes requested while reset is held must be ignored
    bus.mem_to_reg = 1'b0;
    bus.imm        = 16'h0077;
    bus.rd_addr    = 3'd6;
    bus.reg_write  = 1'b1;
    @(posedge clk);
    #1;
    idle();
    bus.rs_addr = 3'd6;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_priority got %h expected 0000", bus.rs_data);
    end
    // Release mid-cycle, then confirm writes resume on the next edge
    #2;
    rst_n = 1'b1;
    write_reg(3'd6, 16'h0042);
    bus.rs_addr = 3'd6;
    #1;
    n_checks++;
    if (bus.rs_data !== 16'h0042) begin
      n_fail++;
      $display("FAIL post_reset_write got %h expected 0042", bus.rs_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_reg_write();
    test_alu_sweep();
    test_store_load();
    test_back_to_back();
    test_neg_imm();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
